// File: rtl/sha_mem_pkg.sv
// Shared types and constants for the SHA-256 memory responder.
package sha_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENG  = 2'd1,
        HOST = 2'd2
    } arb_state_t;

    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 16;
    localparam int HASH_WORDS = 8;

    // SHA-256 initial hash values, handy for benches driving the engine
    localparam logic [WORD_W-1:0] H0 = 32'h6a09e667;
    localparam logic [WORD_W-1:0] H1 = 32'hbb67ae85;
    localparam logic [WORD_W-1:0] H2 = 32'h3c6ef372;
    localparam logic [WORD_W-1:0] H3 = 32'ha54ff53a;
    localparam logic [WORD_W-1:0] H4 = 32'h510e527f;
    localparam logic [WORD_W-1:0] H5 = 32'h9b05688c;
    localparam logic [WORD_W-1:0] H6 = 32'h1f83d9ab;
    localparam logic [WORD_W-1:0] H7 = 32'h5be0cd19;

endpackage

// File: rtl/sha_sp_ram.sv
// Single-port synchronous RAM with registered read; a same-address write returns the old word.
module sha_sp_ram #(
    parameter int DEPTH  = 1024,
    parameter int WORD_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Array is deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sha_mem_responder.sv
// Memory-side responder for the SHA-256 engine: engine/host arbitration over one
// single-port array, plus a write monitor that captures the hash output window.
module sha_mem_responder
    import sha_mem_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter logic [15:0] OUT_BASE   = 16'h0100,
    parameter int          HASH_WORDS = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         eng_active,
    input  logic         mem_we,
    input  logic [15:0]  mem_addr,
    input  logic [31:0]  mem_write_data,
    output logic [31:0]  mem_read_data,
    input  logic         host_req,
    input  logic         host_we,
    input  logic [15:0]  host_addr,
    input  logic [31:0]  host_wdata,
    output logic         host_gnt,
    output logic [31:0]  host_rdata,
    output logic         host_rvalid,
    output logic         hash_valid,
    output logic [255:0] hash_out,
    input  logic         hash_clr,
    output logic         err_oob
);

    localparam int AW = $clog2(DEPTH);

    arb_state_t state, state_nxt;

    logic                  eng_sel;
    logic                  acc;
    logic                  acc_we;
    logic [ADDR_W-1:0]     acc_addr;
    logic [WORD_W-1:0]     acc_wdata;
    logic                  in_range;
    logic [WORD_W-1:0]     ram_rdata;
    logic                  rd_oob;
    logic [ADDR_W-1:0]     cap_off;
    logic                  cap_hit;
    logic [2:0]            cap_idx;
    logic [HASH_WORDS-1:0] mask, mask_nxt, cap_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (eng_active) begin
                    state_nxt = ENG;
                end else if (host_req) begin
                    state_nxt = HOST;
                end
            end
            HOST: begin
                if (eng_active) begin
                    state_nxt = ENG;
                end else if (!host_req) begin
                    state_nxt = IDLE;
                end
            end
            ENG: begin
                if (!eng_active) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Engine also owns the port on the IDLE->ENG cycle so its first address is served.
    assign eng_sel  = (state == ENG) || (state == IDLE && eng_active);
    assign host_gnt = host_req && !eng_active && (state != ENG);

    assign acc       = eng_sel || host_gnt;
    assign acc_we    = eng_sel ? mem_we         : (host_gnt && host_we);
    assign acc_addr  = eng_sel ? mem_addr       : host_addr;
    assign acc_wdata = eng_sel ? mem_write_data : host_wdata;
    assign in_range  = (acc_addr[ADDR_W-1:AW] == '0);

    sha_sp_ram #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (acc),
        .we      (acc_we && in_range),
        .addr    (acc_addr[AW-1:0]),
        .wdata   (acc_wdata),
        .rdata   (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_oob      <= 1'b0;
            host_rvalid <= 1'b0;
            err_oob     <= 1'b0;
        end else begin
            if (acc) begin
                rd_oob <= !in_range;
            end
            host_rvalid <= host_gnt && !host_we;
            if (acc && !in_range) begin
                err_oob <= 1'b1;
            end
        end
    end

    assign mem_read_data = rd_oob ? '0 : ram_rdata;
    assign host_rdata    = mem_read_data;

    assign cap_off = acc_addr - OUT_BASE;
    assign cap_hit = acc && acc_we && (acc_addr >= OUT_BASE)
                     && (cap_off < ADDR_W'(HASH_WORDS));
    assign cap_idx = cap_off[2:0];
    assign cap_bit = cap_hit ? (HASH_WORDS'(1) << cap_idx) : '0;

    // A capture write coinciding with hash_clr keeps its own mask bit.
    assign mask_nxt = (hash_clr ? '0 : mask) | cap_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask       <= '0;
            hash_valid <= 1'b0;
            hash_out   <= '0;
        end else begin
            mask       <= mask_nxt;
            hash_valid <= !hash_clr && (hash_valid || (&mask_nxt));
            if (cap_hit) begin
                hash_out[WORD_W*(HASH_WORDS-1-int'(cap_idx)) +: WORD_W] <= acc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed self-checking bench for sha_mem_responder.
module tb_sha_mem_responder;

    logic         clk;
    logic         reset_n;
    logic         eng_active;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;
    logic         host_req;
    logic         host_we;
    logic [15:0]  host_addr;
    logic [31:0]  host_wdata;
    logic         host_gnt;
    logic [31:0]  host_rdata;
    logic         host_rvalid;
    logic         hash_valid;
    logic [255:0] hash_out;
    logic         hash_clr;
    logic         err_oob;

    int total = 0;
    int bad   = 0;

    sha_mem_responder #(
        .DEPTH      (1024),
        .OUT_BASE   (16'h0100),
        .HASH_WORDS (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .eng_active     (eng_active),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_gnt       (host_gnt),
        .host_rdata     (host_rdata),
        .host_rvalid    (host_rvalid),
        .hash_valid     (hash_valid),
        .hash_out       (hash_out),
        .hash_clr       (hash_clr),
        .err_oob        (err_oob)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and registered outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] exp_hash;

    initial begin
        reset_n        = 1'b1;
        eng_active     = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        host_req       = 1'b0;
        host_we        = 1'b0;
        host_addr      = '0;
        host_wdata     = '0;
        hash_clr       = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mem_read_data", 256'(mem_read_data), 256'h0);
        chk("rst_host_rvalid",   256'(host_rvalid),   256'h0);
        chk("rst_hash_valid",    256'(hash_valid),    256'h0);
        chk("rst_hash_out",      hash_out,            256'h0);
        chk("rst_err_oob",       256'(err_oob),       256'h0);
        chk("rst_host_gnt",      256'(host_gnt),      256'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // host preload of words 0..19
        host_req = 1'b1;
        host_we  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            host_addr  = 16'(i);
            host_wdata = 32'(i);
            #1 chk($sformatf("preload_gnt_%0d", i), 256'(host_gnt), 256'h1);
            tick();
        end
        host_we   = 1'b0;
        host_addr = 16'd5;
        #1 chk("rd5_gnt", 256'(host_gnt), 256'h1);
        tick();
        chk("rd5_rvalid", 256'(host_rvalid), 256'h1);
        chk("rd5_rdata",  256'(host_rdata),  256'h5);
        host_req = 1'b0;
        tick();
        chk("rd5_rvalid_pulse", 256'(host_rvalid), 256'h0);

        // engine read latency, host locked out
        eng_active = 1'b1;
        mem_addr   = 16'd3;
        host_req   = 1'b1;
        host_addr  = 16'd7;
        #1 chk("eng_host_gnt0", 256'(host_gnt), 256'h0);
        tick();
        chk("eng_rd3", 256'(mem_read_data), 256'h3);
        mem_addr = 16'd4;
        #1 chk("eng_host_gnt1", 256'(host_gnt), 256'h0);
        tick();
        chk("eng_rd4", 256'(mem_read_data), 256'h4);
        chk("eng_no_rvalid", 256'(host_rvalid), 256'h0);
        host_req = 1'b0;

        // hash capture, order 7,0..6
        mem_we = 1'b1;
        mem_addr = 16'h0107;
        mem_write_data = 32'hA7;
        tick();
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("cap_valid_pre_%0d", k), 256'(hash_valid), 256'h0);
            mem_addr       = 16'h0100 + 16'(k);
            mem_write_data = 32'hA0 + 32'(k);
            tick();
        end
        mem_we = 1'b0;
        exp_hash = 256'h000000A0_000000A1_000000A2_000000A3_000000A4_000000A5_000000A6_000000A7;
        chk("cap_valid", 256'(hash_valid), 256'h1);
        chk("cap_hash",  hash_out, exp_hash);

        // clear colliding with a write to word 2: only mask bit 2 survives
        mem_we = 1'b1;
        mem_addr = 16'h0102;
        mem_write_data = 32'hB2;
        hash_clr = 1'b1;
        tick();
        hash_clr = 1'b0;
        exp_hash = 256'h000000A0_000000A1_000000B2_000000A3_000000A4_000000A5_000000A6_000000A7;
        chk("clr_valid", 256'(hash_valid), 256'h0);
        chk("clr_hash_held", hash_out, exp_hash);
        for (int k = 0; k < 8; k++) begin
            if (k != 2) begin
                chk($sformatf("refill_valid_pre_%0d", k), 256'(hash_valid), 256'h0);
                mem_addr       = 16'h0100 + 16'(k);
                mem_write_data = 32'hA0 + 32'(k);
                tick();
            end
        end
        chk("refill_valid", 256'(hash_valid), 256'h1);
        chk("refill_hash",  hash_out, exp_hash);
        mem_we   = 1'b0;
        hash_clr = 1'b1;
        tick();
        hash_clr = 1'b0;
        chk("clr_only_valid", 256'(hash_valid), 256'h0);
        chk("clr_only_hash",  hash_out, exp_hash);

        // read-during-write at addr 9 returns the old word
        mem_we = 1'b1;
        mem_addr = 16'd9;
        mem_write_data = 32'h99;
        tick();
        chk("rdw_old", 256'(mem_read_data), 256'h9);
        mem_we = 1'b0;
        tick();
        chk("rdw_new", 256'(mem_read_data), 256'h99);
        eng_active = 1'b0;
        tick();

        // out of range host access, 0x405 would alias word 5
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 16'h0405;
        host_wdata = 32'hDEAD;
        #1 chk("oob_gnt", 256'(host_gnt), 256'h1);
        tick();
        chk("oob_err", 256'(err_oob), 256'h1);
        host_we = 1'b0;
        tick();
        chk("oob_rvalid", 256'(host_rvalid), 256'h1);
        chk("oob_rdata",  256'(host_rdata),  256'h0);
        host_addr = 16'd5;
        tick();
        chk("oob_no_alias", 256'(host_rdata), 256'h5);
        chk("oob_sticky",   256'(err_oob),    256'h1);
        host_req = 1'b0;
        tick();

        // reset in the middle of an engine sequence
        eng_active     = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = 16'd30;
        mem_write_data = 32'h30;
        tick();
        mem_addr       = 16'd31;
        mem_write_data = 32'h31;
        tick();
        mem_addr = 16'd12;
        mem_we   = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("mid_rst_mem_read_data", 256'(mem_read_data), 256'h0);
        chk("mid_rst_err_oob",       256'(err_oob),       256'h0);
        chk("mid_rst_hash_out",      hash_out,            256'h0);
        chk("mid_rst_hash_valid",    256'(hash_valid),    256'h0);
        chk("mid_rst_rvalid",        256'(host_rvalid),   256'h0);
        eng_active = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 16'd30;
        #1 chk("post_rst_gnt", 256'(host_gnt), 256'h1);
        tick();
        chk("post_rst_rd30", 256'(host_rdata), 256'h30);
        host_addr = 16'd9;
        tick();
        chk("post_rst_rd9", 256'(host_rdata), 256'h99);
        host_addr = 16'd19;
        tick();
        chk("post_rst_rd19", 256'(host_rdata), 256'h13);
        host_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
